// File: rtl/vga_pkg.sv
// Shared VGA plot-path definitions: coordinate/colour widths, default screen
// size, pixel payload struct, arbiter state encoding and an on-screen test.
package vga_pkg;

    localparam int unsigned XW               = 8;
    localparam int unsigned YW               = 7;
    localparam int unsigned CW               = 3;
    localparam int unsigned SCREEN_W_DEFAULT = 160;
    localparam int unsigned SCREEN_H_DEFAULT = 120;

    typedef logic [CW-1:0] colour_t;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        colour_t       colour;
    } pixel_t;

    // Unsigned range test; coordinates at or beyond the limit are off-screen.
    function automatic logic on_screen(input pixel_t p, input int unsigned w,
                                       input int unsigned h);
        return (32'(p.x) < w) && (32'(p.y) < h);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   CLOCK_50  in  clock
//   resetn    in  async active-low reset (pointer -> 0)
//   enable_i  in  allow grants this cycle
//   req_i     in  N_REQ request vector
//   gnt_c     out N_REQ one-hot grant (combinational)
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_c
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx_c;
    logic          found_c;

    // Search from the pointer; the winner's successor becomes the new pointer.
    always_comb begin
        gnt_c   = '0;
        ptr_d   = ptr_q;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_c = PW'((32'(ptr_q) + k) % N_REQ);
            if (enable_i && !found_c && req_i[idx_c]) begin
                gnt_c[idx_c] = 1'b1;
                found_c      = 1'b1;
                ptr_d        = (32'(idx_c) == N_REQ - 1) ? '0 : PW'(32'(idx_c) + 1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Owns the VGA adapter plot port: full-screen clear after reset or on
// clear_req, then round-robin sharing between drawing engines, one pixel/clk.
// Ports:
//   CLOCK_50, resetn            clock, async active-low reset
//   clear_req                   pulse: restart the full-screen clear
//   req/req_x/req_y/req_colour  per-engine pixel requests and payloads
//   gnt                         one-hot grant (combinational)
//   clear_done                  high while arbitrating
//   drop                        pulse: granted pixel was off-screen
//   vga_x/vga_y/vga_colour/vga_plot  registered drive to vga_adapter
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned SCREEN_W     = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H     = SCREEN_H_DEFAULT,
    parameter colour_t     CLEAR_COLOUR = 3'b000
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic                       clear_req,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0][XW-1:0]   req_x,
    input  logic [N_REQ-1:0][YW-1:0]   req_y,
    input  logic [N_REQ-1:0][CW-1:0]   req_colour,
    output logic [N_REQ-1:0]           gnt,
    output logic                       clear_done,
    output logic                       drop,
    output logic [XW-1:0]              vga_x,
    output logic [YW-1:0]              vga_y,
    output logic [CW-1:0]              vga_colour,
    output logic                       vga_plot
);

    arb_state_t    state_q, state_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    pixel_t        pix_q, pix_d;
    logic          plot_q, plot_d;
    logic          drop_q, drop_d;
    logic          done_q, done_d;

    logic          arb_en_c;
    pixel_t        win_c;

    // A clear request steals the cycle: no grant, pointer untouched.
    assign arb_en_c = (state_q == ARB) && !clear_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .enable_i (arb_en_c),
        .req_i    (req),
        .gnt_c    (gnt)
    );

    // Winner payload mux.
    always_comb begin
        win_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_c = '{x: req_x[i], y: req_y[i], colour: req_colour[i]};
            end
        end
    end

    // Next state: column-major clear scan, then arbitration.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            CLEAR: begin
                plot_d = 1'b1;
                pix_d  = '{x: cx_q, y: cy_q, colour: CLEAR_COLOUR};
                if (cy_q == YW'(SCREEN_H - 1)) begin
                    cy_d = '0;
                    if (cx_q == XW'(SCREEN_W - 1)) begin
                        cx_d    = '0;
                        state_d = ARB;
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end else begin
                    cy_d = cy_q + YW'(1);
                end
            end
            ARB: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else begin
                    done_d = 1'b1;
                    if (|gnt) begin
                        pix_d = win_c;
                        if (on_screen(win_c, SCREEN_W, SCREEN_H)) begin
                            plot_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= CLEAR;
            cx_q    <= '0;
            cy_q    <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    assign vga_x      = pix_q.x;
    assign vga_y      = pix_q.y;
    assign vga_colour = pix_q.colour;
    assign vga_plot   = plot_q;
    assign drop       = drop_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with an expected-output scoreboard.
module tb_vga_plot_arbiter;

    localparam int unsigned NR   = 2;
    localparam int unsigned W    = 160;
    localparam int unsigned H    = 120;
    localparam int unsigned NPIX = W * H;

    logic                 clk;
    logic                 resetn;
    logic                 clear_req;
    logic [NR-1:0]        req;
    logic [NR-1:0][7:0]   req_x;
    logic [NR-1:0][6:0]   req_y;
    logic [NR-1:0][2:0]   req_colour;
    logic [NR-1:0]        gnt;
    logic                 clear_done;
    logic                 drop;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    typedef struct {
        logic        plot;
        logic        drop;
        logic        done;
        logic [17:0] pix;
    } exp_t;

    exp_t          sbq[$];
    int unsigned   n_pass  = 0;
    int unsigned   n_total = 0;
    int unsigned   m_ptr   = 0;
    logic [17:0]   m_pix   = '0;

    vga_plot_arbiter #(.N_REQ(NR)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .clear_req  (clear_req),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .gnt        (gnt),
        .clear_done (clear_done),
        .drop       (drop),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [17:0] px(input int unsigned x, input int unsigned y,
                                       input int unsigned c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Follows a full clear, starting with the next rising edge.
    task automatic check_clear(input string tag);
        int unsigned bad;
        int unsigned x;
        int unsigned y;
        logic [31:0] got;
        logic [31:0] exp;
        bad = 0;
        x   = 0;
        y   = 0;
        for (int unsigned n = 0; n < NPIX; n++) begin
            if (gnt !== '0) bad++;
            @(posedge clk);
            #1;
            got = {14'b0, vga_x, vga_y, vga_colour};
            exp = {14'b0, 8'(x), 7'(y), 3'b000};
            if (n == 0 || n == 1 || n == NPIX - 1)
                check($sformatf("%s_pix%0d", tag, n), got, exp);
            if (got !== exp || vga_plot !== 1'b1 || clear_done !== 1'b0 || drop !== 1'b0)
                bad++;
            if (y == H - 1) begin
                y = 0;
                x++;
            end else begin
                y++;
            end
        end
        check({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        m_pix = px(W - 1, H - 1, 0);
    endtask

    // One arbitration cycle: drive at negedge, check gnt, check outputs after the edge.
    task automatic cycle(input logic clr, input logic [1:0] r, input logic [17:0] p0,
                         input logic [17:0] p1, input string tag);
        logic [NR-1:0] eg;
        logic [17:0]   pw;
        exp_t          e;
        int unsigned   idx;
        logic          on;
        @(negedge clk);
        clear_req = clr;
        req       = r;
        {req_x[0], req_y[0], req_colour[0]} = p0;
        {req_x[1], req_y[1], req_colour[1]} = p1;
        #1;
        eg     = '0;
        e.plot = 1'b0;
        e.drop = 1'b0;
        e.done = !clr;
        if (!clr) begin
            for (int unsigned k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (eg == '0 && r[idx]) begin
                    eg[idx] = 1'b1;
                    pw      = (idx == 0) ? p0 : p1;
                    m_pix   = pw;
                    m_ptr   = (idx + 1) % NR;
                    on      = (32'(pw[17:10]) < W) && (32'(pw[9:3]) < H);
                    e.plot  = on;
                    e.drop  = !on;
                end
            end
        end
        e.pix = m_pix;
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, "_plot"}, 32'(vga_plot), 32'(e.plot));
        check({tag, "_drop"}, 32'(drop), 32'(e.drop));
        check({tag, "_done"}, 32'(clear_done), 32'(e.done));
        check({tag, "_pix"}, {14'b0, vga_x, vga_y, vga_colour}, {14'b0, e.pix});
        clear_req = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        clear_req  = 1'b0;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;

        #5;
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_pix", {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);

        @(negedge clk);
        resetn = 1'b1;
        check_clear("clear1");
        cycle(1'b0, 2'b00, px(0, 0, 0), px(0, 0, 0), "idle_after_clear");

        cycle(1'b0, 2'b01, px(10, 20, 5), px(0, 0, 0), "single0");
        cycle(1'b0, 2'b00, px(0, 0, 0), px(0, 0, 0), "idle_hold");
        cycle(1'b0, 2'b01, px(159, 119, 7), px(0, 0, 0), "corner_on");

        cycle(1'b0, 2'b10, px(0, 0, 0), px(160, 5, 2), "off_x");
        cycle(1'b0, 2'b10, px(0, 0, 0), px(3, 120, 4), "off_y");
        cycle(1'b0, 2'b00, px(0, 0, 0), px(0, 0, 0), "after_drop");

        for (int i = 0; i < 6; i++)
            cycle(1'b0, 2'b11, px(1, 2, 3), px(100, 110, 6), $sformatf("rr%0d", i));
        cycle(1'b0, 2'b01, px(4, 4, 4), px(0, 0, 0), "ptr_to_1");

        cycle(1'b1, 2'b11, px(1, 2, 3), px(100, 110, 6), "clr_with_req");
        check_clear("clear2");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'b11, px(1, 2, 3), px(100, 110, 6), $sformatf("resume%0d", i));
        cycle(1'b0, 2'b01, px(9, 9, 1), px(0, 0, 0), "ptr_to_1b");

        cycle(1'b1, 2'b00, px(0, 0, 0), px(0, 0, 0), "clr3");
        repeat (50 * H + 61) @(posedge clk);
        #1;
        check("midclear_pos", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, px(50, 60, 0)});
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_plot", 32'(vga_plot), 32'd0);
        check("async_rst_done", 32'(clear_done), 32'd0);
        check("async_rst_pix", {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        m_ptr  = 0;
        check_clear("clear3");
        cycle(1'b0, 2'b11, px(1, 2, 3), px(100, 110, 6), "post_reset");
        cycle(1'b0, 2'b00, px(0, 0, 0), px(0, 0, 0), "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
